// File: rtl/motor_coords_tx_pkg.sv
// Shared definitions for the motor-coordinate frame: FSM states, byte indices
// within a frame and the default end-of-frame marker (reused by the receiver).
package motor_coords_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] IDX_M1L = 3'd0;
    localparam logic [2:0] IDX_M1U = 3'd1;
    localparam logic [2:0] IDX_M2L = 3'd2;
    localparam logic [2:0] IDX_M2U = 3'd3;
    localparam logic [2:0] IDX_M3L = 3'd4;
    localparam logic [2:0] IDX_M3U = 3'd5;
    localparam logic [2:0] IDX_TRL = 3'd6;

    localparam logic [7:0] DEFAULT_TRAILER = 8'd254;

    // Index of the final byte of a frame, with or without the trailer.
    function automatic logic [2:0] last_idx(input bit use_trailer);
        return use_trailer ? IDX_TRL : IDX_M3U;
    endfunction

endpackage

// File: rtl/motor_coords_tx_if.sv
// Byte link between the frame serializer (master) and the UART transmitter (slave).
// tx_start is a one-cycle request with byte_out valid alongside it and held until the
// next request; tx_done_tick is the one-cycle acknowledgement that the byte has left.
interface motor_coords_tx_if;

    logic       tx_start;
    logic [7:0] byte_out;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output byte_out,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  byte_out,
        output tx_done_tick
    );

endinterface

// File: rtl/motor_coords_tx.sv
// Latches three 16-bit motor positions on start_tick and serializes them
// low byte first (plus optional trailer) to the UART transmitter.
module motor_coords_tx
    import motor_coords_tx_pkg::*;
#(
    parameter bit         USE_TRAILER  = 1'b1,
    parameter logic [7:0] TRAILER_BYTE = DEFAULT_TRAILER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_tick,
    input  logic [15:0]        m1_pos,
    input  logic [15:0]        m2_pos,
    input  logic [15:0]        m3_pos,
    motor_coords_tx_if.master  tx,
    output logic               busy,
    output logic               done_tick,
    output state_e             dbg_state
);

    localparam logic [2:0] LAST = last_idx(USE_TRAILER);

    state_e      state;
    logic [2:0]  counter;
    logic [15:0] m1_q;
    logic [15:0] m2_q;
    logic [15:0] m3_q;
    logic        tx_start_q;
    logic [7:0]  byte_q;
    logic [2:0]  next_idx;
    logic [7:0]  next_byte;

    // The byte for the next request is selected ahead so byte_out lands with tx_start.
    assign next_idx = counter + 3'd1;

    always_comb begin
        next_byte = TRAILER_BYTE;
        case (next_idx)
            IDX_M1L: next_byte = m1_q[7:0];
            IDX_M1U: next_byte = m1_q[15:8];
            IDX_M2L: next_byte = m2_q[7:0];
            IDX_M2U: next_byte = m2_q[15:8];
            IDX_M3L: next_byte = m3_q[7:0];
            IDX_M3U: next_byte = m3_q[15:8];
            IDX_TRL: next_byte = TRAILER_BYTE;
            default: next_byte = TRAILER_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            tx_start_q <= 1'b0;
            byte_q     <= '0;
            busy       <= 1'b0;
            done_tick  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_tick  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_tick) begin
                        m1_q       <= m1_pos;
                        m2_q       <= m2_pos;
                        m3_q       <= m3_pos;
                        counter    <= IDX_M1L;
                        byte_q     <= m1_pos[7:0];
                        tx_start_q <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    // start_tick is deliberately not looked at here.
                    if (tx.tx_done_tick) begin
                        if (counter == LAST) begin
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end else begin
                            counter    <= next_idx;
                            byte_q     <= next_byte;
                            tx_start_q <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.tx_start = tx_start_q;
    assign tx.byte_out = byte_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_motor_coords_tx.sv
// Bench for motor_coords_tx: one instance with trailer, one without, sharing stimulus,
// each checked every cycle against a frame-level model and hand-written byte lists.
module tb_motor_coords_tx;
    import motor_coords_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_tick;
    logic        inj_done;
    logic [15:0] m1;
    logic [15:0] m2;
    logic [15:0] m3;
    logic [1:0]  resp_done;
    logic        busy0;
    logic        busy1;
    logic        done0;
    logic        done1;
    state_e      st0;
    state_e      st1;

    motor_coords_tx_if bus0 ();
    motor_coords_tx_if bus1 ();

    assign bus0.tx_done_tick = resp_done[0] | inj_done;
    assign bus1.tx_done_tick = resp_done[1] | inj_done;

    motor_coords_tx #(.USE_TRAILER(1'b1), .TRAILER_BYTE(8'd254)) dut0 (
        .clk(clk), .reset(reset), .start_tick(start_tick),
        .m1_pos(m1), .m2_pos(m2), .m3_pos(m3),
        .tx(bus0), .busy(busy0), .done_tick(done0), .dbg_state(st0)
    );

    motor_coords_tx #(.USE_TRAILER(1'b0), .TRAILER_BYTE(8'd254)) dut1 (
        .clk(clk), .reset(reset), .start_tick(start_tick),
        .m1_pos(m1), .m2_pos(m2), .m3_pos(m3),
        .tx(bus1), .busy(busy1), .done_tick(done1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Frame-level model state per lane (0: with trailer, 1: without).
    bit         m_busy [2];
    bit         m_txs  [2];
    bit         m_done [2];
    logic [7:0] m_byte [2];
    int         m_idx  [2];
    logic [7:0] m_frame[2][7];
    int         m_len  [2] = '{7, 6};
    int         cd     [2];
    int         txs_cnt[2];
    int         done_cnt[2];
    int         last_txs_cyc[2];
    int         done_cyc[2];

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [7:0] f[7];
        f = '{a[7:0], a[15:8], b[7:0], b[15:8], c[7:0], c[15:8], 8'hFE};
        for (int i = 0; i < 7; i++) exp_q0.push_back(f[i]);
        for (int i = 0; i < 6; i++) exp_q1.push_back(f[i]);
    endtask

    task automatic pop_check(input int l, input logic [7:0] act);
        if (l == 0) begin
            if (exp_q0.size() == 0) check("l0_extra_byte", 32'(act), 32'hDEAD);
            else check("l0_byte", 32'(act), 32'(exp_q0.pop_front()));
        end else begin
            if (exp_q1.size() == 0) check("l1_extra_byte", 32'(act), 32'hDEAD);
            else check("l1_byte", 32'(act), 32'(exp_q1.pop_front()));
        end
    endtask

    task automatic monitor();
        logic       a_txs;
        logic       a_done;
        logic       a_busy;
        logic [7:0] a_byte;
        logic       r;
        logic       txd;
        forever begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < 2; l++) begin
                a_txs  = (l == 0) ? bus0.tx_start : bus1.tx_start;
                a_done = (l == 0) ? done0 : done1;
                a_busy = (l == 0) ? busy0 : busy1;
                a_byte = (l == 0) ? bus0.byte_out : bus1.byte_out;
                check(l == 0 ? "l0_tx_start" : "l1_tx_start", 32'(a_txs), 32'(m_txs[l]));
                check(l == 0 ? "l0_done_tick" : "l1_done_tick", 32'(a_done), 32'(m_done[l]));
                check(l == 0 ? "l0_busy" : "l1_busy", 32'(a_busy), 32'(m_busy[l]));
                check(l == 0 ? "l0_byte_out" : "l1_byte_out", 32'(a_byte), 32'(m_byte[l]));
                if (a_txs === 1'b1) begin
                    txs_cnt[l]++;
                    last_txs_cyc[l] = cyc;
                    pop_check(l, a_byte);
                end
                if (a_done === 1'b1) begin
                    done_cnt[l]++;
                    done_cyc[l] = cyc;
                end
                // UART model: acknowledge 10 cycles after each request.
                r = 1'b0;
                if (reset) cd[l] = 0;
                else begin
                    if (cd[l] > 0) begin
                        cd[l]--;
                        if (cd[l] == 0) r = 1'b1;
                    end
                    if (a_txs === 1'b1) cd[l] = 10;
                end
                resp_done[l] = r;
                txd = r | inj_done;
                if (reset) begin
                    m_busy[l] = 0; m_txs[l] = 0; m_done[l] = 0; m_byte[l] = '0; m_idx[l] = 0;
                end else if (m_done[l]) begin
                    m_done[l] = 0;
                    m_busy[l] = 0;
                end else if (!m_busy[l]) begin
                    if (start_tick) begin
                        m_frame[l] = '{m1[7:0], m1[15:8], m2[7:0], m2[15:8], m3[7:0], m3[15:8], 8'd254};
                        m_idx[l]  = 0;
                        m_txs[l]  = 1;
                        m_byte[l] = m_frame[l][0];
                        m_busy[l] = 1;
                    end
                end else if (m_txs[l]) begin
                    m_txs[l] = 0;
                end else if (txd) begin
                    if (m_idx[l] == m_len[l] - 1) m_done[l] = 1;
                    else begin
                        m_idx[l]++;
                        m_txs[l]  = 1;
                        m_byte[l] = m_frame[l][m_idx[l]];
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        start_tick = 1'b1;
        tick(1);
        start_tick = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (done0 !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, 32'(done0), 32'd1);
    endtask

    task automatic wait_txs0(input int target, input string tag);
        int n = 0;
        while (txs_cnt[0] < target && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, 32'(txs_cnt[0] >= target), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start_tick = 1'b0; inj_done = 1'b0;
        m1 = '0; m2 = '0; m3 = '0; resp_done = '0;
        for (int l = 0; l < 2; l++) begin
            m_busy[l] = 0; m_txs[l] = 0; m_done[l] = 0; m_byte[l] = '0; m_idx[l] = 0;
            cd[l] = 0; txs_cnt[l] = 0; done_cnt[l] = 0; last_txs_cyc[l] = 0; done_cyc[l] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        fork
            monitor();
        join_none
        check("rst_tx_start", 32'(bus0.tx_start), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_byte_out", 32'(bus0.byte_out), 32'd0);
        check("rst_state0", 32'(st0), 32'(IDLE));
        check("rst_state1", 32'(st1), 32'(IDLE));
        reset = 1'b0;
        tick(2);

        // Basic frame with and without trailer.
        m1 = 16'h1234; m2 = 16'hABCD; m3 = 16'h00FF;
        exp_q0 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'hFE};
        exp_q1 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
        pulse_start();
        wait_done0("t1_done_timeout");
        tick(2);
        check("t1_tx_count", 32'(txs_cnt[0]), 32'd7);
        check("t2_tx_count", 32'(txs_cnt[1]), 32'd6);
        check("t1_done_count", 32'(done_cnt[0]), 32'd1);
        check("t2_done_count", 32'(done_cnt[1]), 32'd1);
        check("t1_done_latency", 32'(done_cyc[0] - last_txs_cyc[0]), 32'd11);
        check("t2_done_latency", 32'(done_cyc[1] - last_txs_cyc[1]), 32'd11);
        check("t1_busy_after", 32'(busy0), 32'd0);
        check("t2_busy_after", 32'(busy1), 32'd0);

        // Start while busy with changed inputs is ignored.
        push_frame(16'h1234, 16'hABCD, 16'h00FF);
        pulse_start();
        wait_txs0(9, "t3_txs_timeout");
        m1 = 16'h5555;
        pulse_start();
        wait_done0("t3_done_timeout");
        tick(2);
        check("t3_tx_count0", 32'(txs_cnt[0]), 32'd14);
        check("t3_tx_count1", 32'(txs_cnt[1]), 32'd12);
        check("t3_done_count", 32'(done_cnt[0]), 32'd2);

        // Reset after the third byte aborts; a fresh frame follows.
        m2 = 16'h0102; m3 = 16'hA0B0;
        exp_q0.push_back(8'h55); exp_q0.push_back(8'h55); exp_q0.push_back(8'h02);
        exp_q1.push_back(8'h55); exp_q1.push_back(8'h55); exp_q1.push_back(8'h02);
        pulse_start();
        wait_txs0(17, "t4_txs_timeout");
        reset = 1'b1;
        tick(1);
        check("t4_rst_tx_start", 32'(bus0.tx_start), 32'd0);
        check("t4_rst_busy", 32'(busy0), 32'd0);
        check("t4_rst_done", 32'(done0), 32'd0);
        check("t4_rst_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        tick(1);
        check("t4_q_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        m1 = 16'hBEEF; m2 = 16'hCAFE; m3 = 16'h0042;
        exp_q0 = '{8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h42, 8'h00, 8'hFE};
        exp_q1 = '{8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h42, 8'h00};
        pulse_start();
        wait_done0("t4_done_timeout");
        tick(2);
        check("t4_done_count0", 32'(done_cnt[0]), 32'd3);
        check("t4_done_count1", 32'(done_cnt[1]), 32'd3);
        check("t4_tx_count0", 32'(txs_cnt[0]), 32'd24);
        check("t4_tx_count1", 32'(txs_cnt[1]), 32'd21);

        // Stray acknowledgements while idle and during the request cycle.
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        tick(1);
        check("t5_idle_ignored", 32'(txs_cnt[0]), 32'd24);
        m1 = 16'h0706; m2 = 16'h0908; m3 = 16'h0B0A;
        push_frame(16'h0706, 16'h0908, 16'h0B0A);
        pulse_start();
        inj_done = 1'b1;
        tick(1);
        inj_done = 1'b0;
        wait_done0("t5_done_timeout");
        tick(2);
        check("t5_tx_count0", 32'(txs_cnt[0]), 32'd31);
        check("t5_tx_count1", 32'(txs_cnt[1]), 32'd27);

        // Back-to-back: start held through done_tick and the cycle after.
        m1 = 16'h2468; m2 = 16'h1357; m3 = 16'hFFEE;
        push_frame(16'h2468, 16'h1357, 16'hFFEE);
        pulse_start();
        wait_done0("t6_done_timeout");
        push_frame(16'h8001, 16'h4002, 16'h2003);
        m1 = 16'h8001; m2 = 16'h4002; m3 = 16'h2003;
        start_tick = 1'b1;
        tick(1);
        tick(1);
        start_tick = 1'b0;
        check("t6_restart_tx_start", 32'(bus0.tx_start), 32'd1);
        tick(1);
        check("t6_restart_gap", 32'(last_txs_cyc[0] - done_cyc[0]), 32'd2);
        wait_done0("t6_done2_timeout");
        tick(2);
        check("t6_tx_count0", 32'(txs_cnt[0]), 32'd45);
        check("t6_tx_count1", 32'(txs_cnt[1]), 32'd39);
        check("t6_done_count0", 32'(done_cnt[0]), 32'd6);
        check("t6_done_count1", 32'(done_cnt[1]), 32'd6);
        check("final_q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
